// File: rtl/vec_check_pkg.sv
// Shared encodings for the vector-check harness: one-hot FSM states and count modes.
package vec_check_pkg;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_FETCH = 7'b0000010,
    S_LATCH = 7'b0000100,
    S_START = 7'b0001000,
    S_WAIT  = 7'b0010000,
    S_CHECK = 7'b0100000,
    S_DONE  = 7'b1000000
  } state_t;

  localparam logic CNT_MISMATCH = 1'b0;
  localparam logic CNT_MATCH    = 1'b1;

endpackage

// File: rtl/vec_check_harness_if.sv
// ROM read ports and start/ready/done core handshake driven by the harness.
interface vec_check_harness_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] a_address0, b_address0, z_address0;
  logic              a_ce0, b_ce0, z_ce0;
  logic [DATA_W-1:0] a_q0, b_q0, z_q0;
  logic              dut_start, dut_ready, dut_done;
  logic [DATA_W-1:0] dut_a, dut_b;
  logic              dut_zsign;
  logic [DATA_W-1:0] dut_return;

  modport master (
    output a_address0, b_address0, z_address0, a_ce0, b_ce0, z_ce0,
    input  a_q0, b_q0, z_q0,
    output dut_start, dut_a, dut_b, dut_zsign,
    input  dut_ready, dut_done, dut_return
  );

  modport slave (
    input  a_address0, b_address0, z_address0, a_ce0, b_ce0, z_ce0,
    output a_q0, b_q0, z_q0,
    input  dut_start, dut_a, dut_b, dut_zsign,
    output dut_ready, dut_done, dut_return
  );
endinterface

// File: rtl/vec_check_cmp.sv
// Key-gated comparator: a wrong key inverts the equality result.
module vec_check_cmp #(
  parameter int              DATA_W      = 64,
  parameter int              KEY_W       = 16,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 16'hA5C3
) (
  input  logic [DATA_W-1:0] ret,
  input  logic [DATA_W-1:0] exp,
  input  logic [KEY_W-1:0]  key,
  output logic              match
);
  assign match = (ret == exp) ^ (key != CORRECT_KEY);
endmodule

// File: rtl/vec_check_harness.sv
// Walks NUM_VEC ROM vectors through a start/ready/done core and counts pass/fail results.
module vec_check_harness
  import vec_check_pkg::*;
#(
  parameter int               DATA_W       = 64,
  parameter int               NUM_VEC      = 22,
  parameter int               ADDR_W       = 5,
  parameter int               CNT_W        = 5,
  parameter int               TIMEOUT      = 1024,
  parameter int               STOP_ON_FAIL = 0,
  parameter int               KEY_W        = 16,
  parameter logic [KEY_W-1:0] CORRECT_KEY  = 16'hA5C3
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [CNT_W-1:0]  ap_return,
  input  logic              count_mode,
  input  logic [KEY_W-1:0]  locking_key,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_vld,
  output logic              timeout_flag,
  vec_check_harness_if.master bus
);

  localparam int               WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             WD_EN    = (TIMEOUT > 0);
  localparam logic             STOP_EN  = (STOP_ON_FAIL != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WD_W-1:0]   wdog;
  logic [DATA_W-1:0] exp_r, ret_r;
  logic              mode_r, tmo_r, ce_r;
  logic              match_raw, match, bump;

  vec_check_cmp #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .CORRECT_KEY(CORRECT_KEY)
  ) u_cmp (
    .ret(ret_r), .exp(exp_r), .key(locking_key), .match(match_raw)
  );

  // A timed-out vector is always a failure, whatever the key says.
  assign match     = match_raw & ~tmo_r;
  assign bump      = ((match ? CNT_MATCH : CNT_MISMATCH) == mode_r) && (count != '1);
  assign count_nxt = count + CNT_W'(bump);

  assign bus.a_address0 = idx;
  assign bus.b_address0 = idx;
  assign bus.z_address0 = idx;
  assign bus.a_ce0      = ce_r;
  assign bus.b_ce0      = ce_r;
  assign bus.z_ce0      = ce_r;
  assign bus.dut_zsign  = bus.dut_a[DATA_W-1];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state          <= S_IDLE;
      ap_idle        <= 1'b1;
      ap_done        <= 1'b0;
      ap_ready       <= 1'b0;
      ap_return      <= '0;
      count          <= '0;
      idx            <= '0;
      wdog           <= '0;
      exp_r          <= '0;
      ret_r          <= '0;
      mode_r         <= 1'b0;
      tmo_r          <= 1'b0;
      ce_r           <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      timeout_flag   <= 1'b0;
      bus.dut_start  <= 1'b0;
      bus.dut_a      <= '0;
      bus.dut_b      <= '0;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      ce_r     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            count          <= '0;
            idx            <= '0;
            wdog           <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            timeout_flag   <= 1'b0;
            mode_r         <= count_mode;
            ap_idle        <= 1'b0;
            ce_r           <= 1'b1;
            state          <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          bus.dut_a     <= bus.a_q0;
          bus.dut_b     <= bus.b_q0;
          exp_r         <= bus.z_q0;
          tmo_r         <= 1'b0;
          wdog          <= '0;
          bus.dut_start <= 1'b1;
          state         <= S_START;
        end
        S_START: begin
          if (bus.dut_ready) begin
            bus.dut_start <= 1'b0;
            if (bus.dut_done) begin
              ret_r <= bus.dut_return;
              state <= S_CHECK;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.dut_done) begin
            ret_r <= bus.dut_return;
            state <= S_CHECK;
          end else if (WD_EN && wdog == WD_LAST) begin
            timeout_flag <= 1'b1;
            tmo_r        <= 1'b1;
            state        <= S_CHECK;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_CHECK: begin
          count <= count_nxt;
          if (!match && !first_fail_vld) begin
            first_fail_idx <= idx;
            first_fail_vld <= 1'b1;
          end
          if (idx == LAST_IDX || (STOP_EN && !match)) begin
            ap_done   <= 1'b1;
            ap_ready  <= 1'b1;
            ap_return <= count_nxt;
            state     <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            wdog  <= '0;
            ce_r  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          ap_idle <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ap_idle <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_check_harness.sv
// Two harness instances (free-running and stop-on-fail) against ROM/core models and a vector-level reference.
module tb_vec_check_harness;
  import vec_check_pkg::*;

  localparam int DW = 64, NV = 22, AW = 5, CW = 5, KW = 16, TMO = 16;
  localparam logic [KW-1:0] KEY = 16'hA5C3;

  logic clk = 1'b0;
  logic rst, start, cmode;
  logic [KW-1:0] key;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] a_rom [NV];
  logic [DW-1:0] b_rom [NV];
  logic [DW-1:0] z_rom [NV];
  logic [NV-1:0] corrupt;
  int hang_vec;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_h
    vec_check_harness_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    logic done, ready, idle, ffv, tmo;
    logic [CW-1:0] ret;
    logic [AW-1:0] ffi;

    vec_check_harness #(
      .DATA_W(DW), .NUM_VEC(NV), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TMO),
      .STOP_ON_FAIL(g), .KEY_W(KW), .CORRECT_KEY(KEY)
    ) dut (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done), .ap_idle(idle),
      .ap_ready(ready), .ap_return(ret), .count_mode(cmode), .locking_key(key),
      .first_fail_idx(ffi), .first_fail_vld(ffv), .timeout_flag(tmo), .bus(bus.master)
    );

    int n_done = 0, n_drm = 0, n_fetch = 0, last_a = -1, cur = -1, mode = 0, cnt = 0;
    logic pend = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] res = '0;

    // ROM with one-cycle latency plus a core with random ready delay and latency.
    always @(negedge clk) begin
      if (done) n_done++;
      if (done !== ready) n_drm++;
      if (pend) begin
        bus.a_q0 = a_rom[pa]; bus.b_q0 = b_rom[pa]; bus.z_q0 = z_rom[pa];
      end else begin
        bus.a_q0 = {$urandom, $urandom}; bus.b_q0 = {$urandom, $urandom};
        bus.z_q0 = {$urandom, $urandom};
      end
      pend = bus.a_ce0;
      pa   = bus.a_address0;
      if (bus.a_ce0) begin
        n_fetch++;
        last_a = int'(bus.a_address0);
        cur    = int'(bus.a_address0);
      end
      bus.dut_ready = 1'b0;
      bus.dut_done  = 1'b0;
      if (rst) mode = 0;
      else begin
        if (mode == 0 && bus.dut_start) begin
          cnt = $urandom_range(0, 2); mode = 1;
        end
        if (mode == 1) begin
          if (cnt == 0) begin
            bus.dut_ready = 1'b1;
            chk($sformatf("i%0d op_a", g), bus.dut_a, a_rom[cur]);
            chk($sformatf("i%0d op_b", g), bus.dut_b, b_rom[cur]);
            chk($sformatf("i%0d zsign", g), DW'(bus.dut_zsign), DW'(a_rom[cur][DW-1]));
            res = (bus.dut_a + bus.dut_b) ^ DW'(corrupt[cur]);
            if (cur == hang_vec) mode = 0;
            else begin cnt = $urandom_range(0, 4); mode = 2; end
          end else cnt--;
        end
        if (mode == 2) begin
          if (cnt == 0) begin
            bus.dut_done = 1'b1; bus.dut_return = res; mode = 0;
          end else cnt--;
        end
      end
    end
  end

  // Vector-level reference: walk the vectors and apply the match/count/stop rules directly.
  function automatic void model(input bit stop, input logic [NV-1:0] bad, input int hang,
                                input bit wk, input bit m, output int cnt, output int ffi,
                                output bit ffv, output bit tmo, output int nvis);
    cnt = 0; ffi = 0; ffv = 0; tmo = 0; nvis = 0;
    for (int i = 0; i < NV; i++) begin
      bit ok;
      nvis++;
      if (i == hang) begin ok = 0; tmo = 1; end
      else ok = (!bad[i]) ^ wk;
      if (ok == m && cnt < (1 << CW) - 1) cnt++;
      if (!ok && !ffv) begin ffv = 1; ffi = i; end
      if (stop && !ok) break;
    end
  endfunction

  task automatic cmp_inst(input int g, input logic [NV-1:0] bad, input int hang, input bit wk,
                          input bit m, input int dn, input int nf, input int la, input int drm,
                          input logic [CW-1:0] r, input logic [AW-1:0] fi, input logic fv,
                          input logic tf, input logic idl);
    int ecnt, effi, envis;
    bit effv, etmo;
    model(g != 0, bad, hang, wk, m, ecnt, effi, effv, etmo, envis);
    chk($sformatf("i%0d ap_return", g), DW'(r), DW'(ecnt));
    chk($sformatf("i%0d ff_vld", g), DW'(fv), DW'(effv));
    if (effv) chk($sformatf("i%0d ff_idx", g), DW'(fi), DW'(effi));
    chk($sformatf("i%0d timeout", g), DW'(tf), DW'(etmo));
    chk($sformatf("i%0d done_pulses", g), DW'(dn), 1);
    chk($sformatf("i%0d fetches", g), DW'(nf), DW'(envis));
    chk($sformatf("i%0d last_addr", g), DW'(la), DW'(envis - 1));
    chk($sformatf("i%0d ready_eq_done", g), DW'(drm), 0);
    chk($sformatf("i%0d idle_after", g), DW'(idl), 1);
  endtask

  task automatic fill_roms();
    for (int i = 0; i < NV; i++) begin
      a_rom[i] = {$urandom, $urandom};
      b_rom[i] = {$urandom, $urandom};
      z_rom[i] = a_rom[i] + b_rom[i];
    end
  endtask

  task automatic run(input logic [NV-1:0] bad, input int hang, input logic [KW-1:0] k, input bit m);
    int d0, d1, f0, f1, r0, r1, budget;
    corrupt = bad; hang_vec = hang; key = k; cmode = m;
    fill_roms();
    d0 = g_h[0].n_done; d1 = g_h[1].n_done;
    f0 = g_h[0].n_fetch; f1 = g_h[1].n_fetch;
    r0 = g_h[0].n_drm; r1 = g_h[1].n_drm;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    budget = 0;
    while ((g_h[0].n_done == d0 || g_h[1].n_done == d1) && budget < 3000) begin
      @(negedge clk); budget++;
    end
    chk("run_in_budget", DW'(budget < 3000), 1);
    repeat (4) @(negedge clk);
    cmp_inst(0, bad, hang, k != KEY, m, g_h[0].n_done - d0, g_h[0].n_fetch - f0, g_h[0].last_a,
             g_h[0].n_drm - r0, g_h[0].ret, g_h[0].ffi, g_h[0].ffv, g_h[0].tmo, g_h[0].idle);
    cmp_inst(1, bad, hang, k != KEY, m, g_h[1].n_done - d1, g_h[1].n_fetch - f1, g_h[1].last_a,
             g_h[1].n_drm - r1, g_h[1].ret, g_h[1].ffi, g_h[1].ffv, g_h[1].tmo, g_h[1].idle);
  endtask

  initial begin
    int b, dn;
    logic [NV-1:0] two_bad;
    rst = 1'b1; start = 1'b0; cmode = 1'b0; key = KEY; corrupt = '0; hang_vec = -1;
    fill_roms();
    repeat (3) @(negedge clk);
    chk("rst idle", DW'(g_h[0].idle), 1);
    chk("rst done", DW'(g_h[0].done), 0);
    chk("rst return", DW'(g_h[0].ret), 0);
    chk("rst ff_vld", DW'(g_h[0].ffv), 0);
    chk("rst timeout", DW'(g_h[0].tmo), 0);
    chk("rst dut_start", DW'(g_h[0].bus.dut_start), 0);
    chk("rst ce", DW'(g_h[0].bus.a_ce0), 0);
    rst = 1'b0;
    @(negedge clk);

    two_bad = '0; two_bad[5] = 1'b1; two_bad[17] = 1'b1;
    run('0, -1, KEY, 1'b0);
    run(two_bad, -1, KEY, 1'b0);
    run(two_bad, -1, KEY, 1'b1);
    run('0, -1, 16'h0000, 1'b0);
    run(NV'(1) << 3, -1, KEY, 1'b0);
    run('0, 7, KEY, 1'b0);

    // Abort during the WAIT of vector 10, after a run that left a non-zero return.
    run(two_bad, -1, KEY, 1'b0);
    corrupt = '0; hang_vec = 10; key = KEY; cmode = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    b = 0;
    while (g_h[0].cur != 10 && b < 2000) begin @(negedge clk); b++; end
    chk("reach_vec10", DW'(b < 2000), 1);
    repeat (7) @(negedge clk);
    dn = g_h[0].n_done;
    rst = 1'b1;
    @(negedge clk);
    chk("abort idle", DW'(g_h[0].idle), 1);
    chk("abort dut_start", DW'(g_h[0].bus.dut_start), 0);
    chk("abort return", DW'(g_h[0].ret), 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort no_done", DW'(g_h[0].n_done - dn), 0);
    run('0, -1, KEY, 1'b0);

    for (int t = 0; t < 4; t++) begin
      logic [NV-1:0] rb;
      rb = NV'({$urandom, $urandom}) & NV'($urandom);
      run(rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NV - 1)) : -1,
          ($urandom_range(0, 2) == 0) ? KW'($urandom) : KEY, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
